// File: rtl/inst_fetch_port_pkg.sv
// Shared widths and the response entry layout for the instruction fetch port.
package inst_fetch_port_pkg;

    localparam int MMU_FLAGS_W = 14;
    localparam int INST_W      = 32;
    localparam int RESP_W      = 1 + MMU_FLAGS_W + INST_W;

    typedef struct packed {
        logic                   pagefault;
        logic [MMU_FLAGS_W-1:0] mmu_flags;
        logic [INST_W-1:0]      data;
    } resp_t;

endpackage

// File: rtl/inst_fetch_port_sync_fifo.sv
// Synchronous FIFO with single-cycle clear (iREMOVE), used to buffer memory responses.
module inst_fetch_port_sync_fifo
    import inst_fetch_port_pkg::*;
#(
    parameter int P_N       = RESP_W,
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iREMOVE,
    input  logic                 iWR_EN,
    input  logic [P_N-1:0]       iWR_DATA,
    input  logic                 iRD_EN,
    output logic [P_N-1:0]       oRD_DATA,
    output logic                 oEMPTY,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam logic [P_DEPTH_N:0] DEPTH_C = (P_DEPTH_N+1)'(P_DEPTH);

    logic [P_N-1:0]     mem_q [P_DEPTH];
    logic [P_DEPTH_N:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N:0] rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (iREMOVE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (iWR_EN) wr_ptr_d = wr_ptr_q + 1'b1;
            if (iRD_EN) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iWR_EN && !iREMOVE) mem_q[wr_ptr_q[P_DEPTH_N-1:0]] <= iWR_DATA;
    end

    assign oCOUNT   = wr_ptr_q - rd_ptr_q;
    assign oEMPTY   = (oCOUNT == '0);
    assign oRD_DATA = mem_q[rd_ptr_q[P_DEPTH_N-1:0]];

`ifndef SYNTHESIS
    always_ff @(posedge iCLOCK) begin
        if (!iRESET_SYNC && !iREMOVE)
            assert (!(iWR_EN && (oCOUNT == DEPTH_C)))
            else $error("inst_fetch_port_sync_fifo: push into full FIFO");
    end
`endif

endmodule

// File: rtl/inst_fetch_port.sv
// Fetch-stage to instruction-memory bridge: credit-limited issue, flush discard, response FIFO.
// Optional same-cycle response bypass when INST_FETCH_PORT_BYPASS_EN is defined.
module inst_fetch_port
    import inst_fetch_port_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    input  logic                   iFLUSH,
    input  logic                   iFETCH_REQ,
    input  logic [1:0]             iFETCH_MMUMOD,
    input  logic [31:0]            iFETCH_ADDR,
    output logic                   oFETCH_LOCK,
    output logic                   oINST_VALID,
    output logic                   oINST_PAGEFAULT,
    output logic [MMU_FLAGS_W-1:0] oINST_MMU_FLAGS,
    output logic [31:0]            oINST,
    input  logic                   iINST_LOCK,
    output logic                   oMEM_REQ,
    output logic [1:0]             oMEM_MMUMOD,
    output logic [31:0]            oMEM_ADDR,
    input  logic                   iMEM_LOCK,
    input  logic                   iMEM_VALID,
    input  logic                   iMEM_PAGEFAULT,
    input  logic [MMU_FLAGS_W-1:0] iMEM_MMU_FLAGS,
    input  logic [31:0]            iMEM_DATA
);

    localparam logic [P_DEPTH_N+1:0] DEPTH_C = (P_DEPTH_N+2)'(P_DEPTH);

    logic [P_DEPTH_N:0]   inflight_q, inflight_d;
    logic [P_DEPTH_N:0]   discard_q, discard_d;
    logic [P_DEPTH_N:0]   fifo_count;
    logic [P_DEPTH_N+1:0] credit_used;
    logic [P_DEPTH_N:0]   req_ext, rsp_ext;
    logic                 fifo_empty, discard_zero;
    logic                 push, pop, bypass;
    resp_t                mem_resp, fifo_head, out_resp;

    assign mem_resp     = {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA};
    assign discard_zero = (discard_q == '0);

    // Credit check uses registered counts only, so a pop this cycle frees nothing yet.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign oFETCH_LOCK = iMEM_LOCK || (credit_used >= DEPTH_C);
    assign oMEM_REQ    = iFETCH_REQ && !oFETCH_LOCK && !iFLUSH;
    assign oMEM_ADDR   = iFETCH_ADDR;
    assign oMEM_MMUMOD = iFETCH_MMUMOD;

`ifdef INST_FETCH_PORT_BYPASS_EN
    assign bypass = fifo_empty && iMEM_VALID && discard_zero && !iINST_LOCK && !iFLUSH;
`else
    assign bypass = 1'b0;
`endif

    assign push        = iMEM_VALID && discard_zero && !iFLUSH && !bypass;
    assign pop         = !fifo_empty && !iINST_LOCK && !iFLUSH;
    assign oINST_VALID = pop || bypass;

    always_comb begin
        out_resp = '0;
        if (!fifo_empty)  out_resp = fifo_head;
        else if (bypass)  out_resp = mem_resp;
    end

    assign oINST_PAGEFAULT = out_resp.pagefault;
    assign oINST_MMU_FLAGS = out_resp.mmu_flags;
    assign oINST           = out_resp.data;

    assign req_ext = {{P_DEPTH_N{1'b0}}, oMEM_REQ};
    assign rsp_ext = {{P_DEPTH_N{1'b0}}, iMEM_VALID};

    // On flush every response still outstanding after this cycle is stale.
    always_comb begin
        inflight_d = inflight_q + req_ext - rsp_ext;
        discard_d  = discard_q;
        if (iFLUSH)
            discard_d = inflight_q - rsp_ext;
        else if (iMEM_VALID && !discard_zero)
            discard_d = discard_q - rsp_ext;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    inst_fetch_port_sync_fifo #(RESP_W, P_DEPTH, P_DEPTH_N) u_resp_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iREMOVE     (iFLUSH),
        .iWR_EN      (push),
        .iWR_DATA    (mem_resp),
        .iRD_EN      (pop),
        .oRD_DATA    (fifo_head),
        .oEMPTY      (fifo_empty),
        .oCOUNT      (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed self-checking bench for inst_fetch_port (honours INST_FETCH_PORT_BYPASS_EN).
module tb_inst_fetch_port;

    logic        clk = 1'b0;
    logic        rst, flush, fetch_req, fetch_lock;
    logic [1:0]  fetch_mmumod, mem_mmumod;
    logic [31:0] fetch_addr, mem_addr, inst, mem_data;
    logic        inst_valid, inst_pf, inst_lock, mem_req, mem_lock, mem_valid, mem_pf;
    logic [13:0] inst_flags, mem_flags;
    int total = 0;
    int bad   = 0;

`ifdef INST_FETCH_PORT_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    inst_fetch_port dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
        .iFETCH_REQ(fetch_req), .iFETCH_MMUMOD(fetch_mmumod), .iFETCH_ADDR(fetch_addr),
        .oFETCH_LOCK(fetch_lock), .oINST_VALID(inst_valid), .oINST_PAGEFAULT(inst_pf),
        .oINST_MMU_FLAGS(inst_flags), .oINST(inst), .iINST_LOCK(inst_lock),
        .oMEM_REQ(mem_req), .oMEM_MMUMOD(mem_mmumod), .oMEM_ADDR(mem_addr),
        .iMEM_LOCK(mem_lock), .iMEM_VALID(mem_valid), .iMEM_PAGEFAULT(mem_pf),
        .iMEM_MMU_FLAGS(mem_flags), .iMEM_DATA(mem_data)
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; fetch_req = 0; fetch_mmumod = 0; fetch_addr = 0; inst_lock = 0;
        mem_lock = 0; mem_valid = 0; mem_pf = 0; mem_flags = 0; mem_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
        total++; if (inst_pf !== 1'b0) begin bad++; $display("FAIL reset_pf got=%b exp=0", inst_pf); end
        total++; if (inst_flags !== 14'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", inst_flags); end
        total++; if (fetch_lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b exp=0", fetch_lock); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b exp=0", mem_req); end
        mem_lock = 1;
        #1;
        total++; if (fetch_lock !== 1'b1) begin bad++; $display("FAIL reset_lock_memlock got=%b exp=1", fetch_lock); end
        mem_lock = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_streaming();
        logic exp_v;
        for (int c = 0; c < 13; c++) begin
            idle_inputs();
            fetch_req    = (c < 8);
            fetch_addr   = 32'(4 * c);
            fetch_mmumod = 2'(c);
            mem_valid    = (c >= 2 && c < 10);
            mem_data     = img(32'(4 * (c - 2)));
            #1;
            total++; if (mem_req !== (c < 8)) begin bad++; $display("FAIL stream_req c=%0d got=%b exp=%b", c, mem_req, (c < 8)); end
            if (c < 8) begin
                total++; if (mem_addr !== 32'(4 * c) || mem_mmumod !== 2'(c)) begin
                    bad++; $display("FAIL stream_addr c=%0d got=%h/%0d exp=%h/%0d", c, mem_addr, mem_mmumod, 32'(4 * c), 2'(c));
                end
            end
            exp_v = (c >= 2 + LAT && c < 10 + LAT);
            total++; if (inst_valid !== exp_v) begin bad++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, inst_valid, exp_v); end
            if (exp_v) begin
                total++; if (inst !== img(32'(4 * (c - 2 - LAT)))) begin
                    bad++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, inst, img(32'(4 * (c - 2 - LAT))));
                end
            end
            tick();
        end
    endtask

    task automatic test_credit_lock();
        logic exp_lock, exp_v, exp_req;
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            fetch_req  = (c <= 8);
            fetch_addr = 32'h80 + 32'(4 * c);
            mem_valid  = (c >= 4 && c < 8);
            mem_data   = img(32'h80 + 32'(4 * (c - 4)));
            inst_lock  = (c < 8);
            #1;
            exp_lock = (c >= 4 && c <= 8);
            exp_req  = (c <= 8) && !exp_lock;
            exp_v    = (c >= 8 && c < 12);
            total++; if (fetch_lock !== exp_lock) begin bad++; $display("FAIL credit_lock c=%0d got=%b exp=%b", c, fetch_lock, exp_lock); end
            total++; if (mem_req !== exp_req) begin bad++; $display("FAIL credit_req c=%0d got=%b exp=%b", c, mem_req, exp_req); end
            total++; if (inst_valid !== exp_v) begin bad++; $display("FAIL credit_valid c=%0d got=%b exp=%b", c, inst_valid, exp_v); end
            if (exp_v) begin
                total++; if (inst !== img(32'h80 + 32'(4 * (c - 8)))) begin
                    bad++; $display("FAIL credit_data c=%0d got=%h exp=%h", c, inst, img(32'h80 + 32'(4 * (c - 8))));
                end
            end
            tick();
        end
    endtask

    task automatic test_flush_inflight();
        logic exp_v, exp_req;
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            fetch_req  = (c <= 4);
            fetch_addr = (c < 3) ? 32'h40 + 32'(4 * c) : ((c == 3) ? 32'h60 : 32'h100);
            flush      = (c == 3);
            mem_valid  = (c >= 5 && c <= 8);
            mem_data   = (c < 8) ? img(32'h40 + 32'(4 * (c - 5))) : img(32'h100);
            #1;
            exp_req = (c <= 4) && (c != 3);
            exp_v   = (c == 8 + LAT);
            total++; if (mem_req !== exp_req) begin bad++; $display("FAIL flush_req c=%0d got=%b exp=%b", c, mem_req, exp_req); end
            total++; if (inst_valid !== exp_v) begin bad++; $display("FAIL flush_valid c=%0d got=%b exp=%b", c, inst_valid, exp_v); end
            if (exp_v) begin
                total++; if (inst !== img(32'h100)) begin bad++; $display("FAIL flush_data c=%0d got=%h exp=%h", c, inst, img(32'h100)); end
            end
            tick();
        end
    endtask

    task automatic test_flush_coincident();
        logic exp_v;
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            fetch_req  = (c < 2 || c == 5);
            fetch_addr = (c < 2) ? 32'h200 + 32'(4 * c) : 32'h208;
            mem_valid  = (c == 3 || c == 4 || c == 6);
            mem_data   = (c == 3) ? img(32'h200) : ((c == 4) ? img(32'h204) : img(32'h208));
            flush      = (c == 3);
            #1;
            exp_v = (c == 6 + LAT);
            total++; if (inst_valid !== exp_v) begin bad++; $display("FAIL coinc_valid c=%0d got=%b exp=%b", c, inst_valid, exp_v); end
            if (exp_v) begin
                total++; if (inst !== img(32'h208)) begin bad++; $display("FAIL coinc_data c=%0d got=%h exp=%h", c, inst, img(32'h208)); end
            end
            tick();
        end
    endtask

    task automatic test_flush_locked();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            fetch_req  = (c == 0);
            fetch_addr = 32'h180;
            mem_valid  = (c == 1);
            mem_data   = img(32'h180);
            inst_lock  = (c <= 2);
            flush      = (c == 2);
            #1;
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL flocked_valid c=%0d got=%b exp=0", c, inst_valid); end
            if (c == 2) begin
                total++; if (inst !== img(32'h180)) begin bad++; $display("FAIL flocked_head got=%h exp=%h", inst, img(32'h180)); end
            end
            if (c == 3) begin
                total++; if (inst !== 32'h0) begin bad++; $display("FAIL flocked_cleared got=%h exp=0", inst); end
            end
            tick();
        end
    endtask

    task automatic test_pagefault();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            fetch_req  = (c == 0);
            fetch_addr = 32'h300;
            mem_valid  = (c == 2);
            mem_pf     = (c == 2);
            mem_flags  = (c == 2) ? 14'h2A5 : 14'h0;
            mem_data   = (c == 2) ? img(32'h300) : 32'h0;
            #1;
            if (c == 2 + LAT) begin
                total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL pf_valid got=%b exp=1", inst_valid); end
                total++; if (inst_pf !== 1'b1) begin bad++; $display("FAIL pf_bit got=%b exp=1", inst_pf); end
                total++; if (inst_flags !== 14'h2A5) begin bad++; $display("FAIL pf_flags got=%h exp=2a5", inst_flags); end
                total++; if (inst !== img(32'h300)) begin bad++; $display("FAIL pf_data got=%h exp=%h", inst, img(32'h300)); end
            end
            if (c == 3 + LAT) begin
                total++; if (inst_pf !== 1'b0 || inst_flags !== 14'h0) begin
                    bad++; $display("FAIL pf_empty got=%b/%h exp=0/0", inst_pf, inst_flags);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass_latency();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            fetch_req  = (c == 0);
            fetch_addr = 32'h500;
            mem_valid  = (c == 1);
            mem_data   = img(32'h500);
            #1;
            total++; if (inst_valid !== (c == 1 + LAT)) begin
                bad++; $display("FAIL lat_valid c=%0d got=%b exp=%b", c, inst_valid, (c == 1 + LAT));
            end
            if (c == 1 + LAT) begin
                total++; if (inst !== img(32'h500)) begin bad++; $display("FAIL lat_data got=%h exp=%h", inst, img(32'h500)); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            inst_lock  = (c <= 5);
            fetch_req  = (c <= 1 || c == 6);
            fetch_addr = (c <= 1) ? 32'h400 + 32'(4 * c) : 32'h408;
            mem_valid  = (c == 2 || c == 3 || c == 7);
            mem_data   = (c == 7) ? img(32'h408) : img(32'h400 + 32'(4 * (c - 2)));
            rst        = (c == 5);
            #1;
            if (c == 4) begin
                total++; if (inst_valid !== 1'b0 || inst !== img(32'h400)) begin
                    bad++; $display("FAIL midrst_buffered got=%b/%h exp=0/%h", inst_valid, inst, img(32'h400));
                end
            end
            if (c == 6) begin
                total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pf !== 1'b0 || inst_flags !== 14'h0) begin
                    bad++; $display("FAIL midrst_outputs got=%b/%h/%b/%h exp=0/0/0/0", inst_valid, inst, inst_pf, inst_flags);
                end
                total++; if (fetch_lock !== 1'b0) begin bad++; $display("FAIL midrst_lock got=%b exp=0", fetch_lock); end
            end
            if (c == 7 + LAT) begin
                total++; if (inst_valid !== 1'b1 || inst !== img(32'h408)) begin
                    bad++; $display("FAIL midrst_after got=%b/%h exp=1/%h", inst_valid, inst, img(32'h408));
                end
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_credit_lock();
        test_flush_inflight();
        test_flush_coincident();
        test_flush_locked();
        test_pagefault();
        test_bypass_latency();
        test_reset_midop();
        idle_inputs();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
